// File: rtl/uart_tx.sv
// Bus-programmable UART transmitter: 8N1 frames from a small TX FIFO.
// Bus handshake: every req_i cycle is accepted (no stall); exactly one cycle
// later rvalid_o is high for one cycle with rdata_o/err_o valid; outside that
// cycle rdata_o and err_o are held at 0.
module uart_tx #(
   parameter int FifoDepth   = 8,
   parameter int ClkDivReset = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        tx_o,
   output logic        intr_o
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int CntW = PtrW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   // Registers and FSM state
   state_e            state_q, state_d;
   logic [2:0]        bit_q, bit_d;
   logic [15:0]       cyc_q, cyc_d;
   logic [15:0]       div_q, div_d;
   logic [7:0]        sh_q, sh_d;
   logic              tx_q, tx_d;
   logic [15:0]       clkdiv_q;
   logic              tx_en_q, irq_en_q;
   logic              intr_q;
   logic              rvalid_q, err_q;
   logic [31:0]       rdata_q;

   // FIFO storage
   logic [7:0]        mem [FifoDepth];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;

   // Bus decode
   logic [7:0]  reg_idx;
   logic        sel_txdata, sel_status, sel_clkdiv, sel_ctrl, sel_none;
   logic        wr, rd, push, pop, fifo_full, fifo_empty, busy, cyc_last;
   logic        err_d;
   logic [31:0] rdata_d;
   logic [15:0] clkdiv_merged;
   logic        unused_bits;

   assign unused_bits = ^{addr_i[31:10], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

   assign reg_idx    = addr_i[9:2];
   assign sel_txdata = (reg_idx == 8'd0);
   assign sel_status = (reg_idx == 8'd1);
   assign sel_clkdiv = (reg_idx == 8'd2);
   assign sel_ctrl   = (reg_idx == 8'd3);
   assign sel_none   = ~(sel_txdata | sel_status | sel_clkdiv | sel_ctrl);
   assign wr         = req_i & we_i;
   assign rd         = req_i & ~we_i;

   assign fifo_full  = (count_q == CntW'(FifoDepth));
   assign fifo_empty = (count_q == '0);
   assign busy       = (state_q != IDLE);
   // Fullness is judged before any same-cycle pop, so a push into a full FIFO
   // is always dropped.
   assign push       = wr & sel_txdata & be_i[0] & ~fifo_full;
   assign cyc_last   = (cyc_q == div_q - 16'd1);

   assign clkdiv_merged = {be_i[1] ? wdata_i[15:8] : clkdiv_q[15:8],
                           be_i[0] ? wdata_i[7:0]  : clkdiv_q[7:0]};

   // Response data and error for the current request
   always_comb begin
      rdata_d = '0;
      err_d   = req_i & (sel_none | (we_i & sel_status) |
                         (we_i & sel_txdata & be_i[0] & fifo_full));
      if (rd) begin
         if (sel_status) begin
            rdata_d[0]    = busy;
            rdata_d[1]    = fifo_full;
            rdata_d[2]    = fifo_empty;
            rdata_d[13:8] = 6'(count_q);
         end else if (sel_clkdiv) begin
            rdata_d[15:0] = clkdiv_q;
         end else if (sel_ctrl) begin
            rdata_d[1:0]  = {irq_en_q, tx_en_q};
         end
      end
   end

   // Bus response, control registers and level interrupt
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         clkdiv_q <= 16'(ClkDivReset);
         tx_en_q  <= 1'b1;
         irq_en_q <= 1'b0;
         intr_q   <= 1'b0;
      end else begin
         rvalid_q <= req_i;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         if (wr && sel_clkdiv)
            clkdiv_q <= (clkdiv_merged == 16'd0) ? 16'd1 : clkdiv_merged;
         if (wr && sel_ctrl && be_i[0]) begin
            tx_en_q  <= wdata_i[0];
            irq_en_q <= wdata_i[1];
         end
         intr_q <= irq_en_q & fifo_empty & ~busy;
      end
   end

   // FIFO storage write (contents need no reset; level tracks validity)
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= wdata_i[7:0];
   end

   // FIFO pointers and level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
      end
   end

   // Serializer next state; tx line is registered from the next state
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      div_d   = div_q;
      sh_d    = sh_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_en_q && !fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
               cyc_d   = '0;
               bit_d   = '0;
               div_d   = clkdiv_q;
               sh_d    = mem[rd_ptr_q];
            end
         end
         START: begin
            if (cyc_last) begin
               state_d = DATA;
               cyc_d   = '0;
               bit_d   = '0;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         DATA: begin
            if (cyc_last) begin
               cyc_d = '0;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         STOP: begin
            if (cyc_last) begin
               cyc_d = '0;
               bit_d = '0;
               if (tx_en_q && !fifo_empty) begin
                  pop     = 1'b1;
                  state_d = START;
                  div_d   = clkdiv_q;
                  sh_d    = mem[rd_ptr_q];
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   // Serializer state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         bit_q   <= '0;
         cyc_q   <= '0;
         div_q   <= 16'd1;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         div_q   <= div_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign tx_o     = tx_q;
   assign intr_o   = intr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: register access, frame shape, FIFO limits,
// interrupt timing and mid-frame reset.
module tb_uart_tx;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        tx_o;
   logic        intr_o;

   int n_cmp = 0;
   int n_mis = 0;

   uart_tx #(.FifoDepth(8), .ClkDivReset(16)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (req_i),
      .we_i    (we_i),
      .be_i    (be_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rvalid_o(rvalid_o),
      .rdata_o (rdata_o),
      .err_o   (err_o),
      .tx_o    (tx_o),
      .intr_o  (intr_o)
   );

   // clock and watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] rdat, output logic er);
      @(negedge clk_i);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
      @(posedge clk_i);
      #1;
      req_i = 1'b0; we_i = 1'b0; be_i = '0;
      @(negedge clk_i);
      check("rvalid", {31'b0, rvalid_o}, 32'd1);
      rdat = rdata_o;
      er   = err_o;
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic exp_err);
      logic [31:0] rdat;
      logic        er;
      bus(1'b1, a, d, b, rdat, er);
      check(tag, {31'b0, er}, {31'b0, exp_err});
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a,
                         input logic [31:0] exp, input logic exp_err);
      logic [31:0] rdat;
      logic        er;
      bus(1'b0, a, 32'h0, 4'hF, rdat, er);
      check({tag, "_data"}, rdat, exp);
      check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_tx", {31'b0, tx_o}, 32'd1);
      check("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
      check("rst_intr", {31'b0, intr_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      rst_ni = 1'b1;
   endtask

   task automatic wait_tx_low(input int bound);
      logic found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk_i);
         if (tx_o == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check("start_seen", {31'b0, found}, 32'd1);
   endtask

   // Caller stands on the first start-bit sample; checks every cycle of the frame.
   task automatic frame_check(input string tag, input logic [7:0] data, input int d);
      logic [9:0] bits;
      bits = {1'b1, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < d; c++) begin
            if (b != 0 || c != 0) @(negedge clk_i);
            check($sformatf("%s_bit%0d_c%0d", tag, b, c), {31'b0, tx_o}, {31'b0, bits[b]});
         end
      end
   endtask

   initial begin
      logic seen_low;

      // reset and reset values
      apply_reset();
      rd_chk("clkdiv_rst", 32'h08, 32'd16, 1'b0);
      rd_chk("ctrl_rst", 32'h0C, 32'd1, 1'b0);
      rd_chk("status_rst", 32'h04, 32'h4, 1'b0);
      rd_chk("txdata_rd", 32'h00, 32'h0, 1'b0);
      @(negedge clk_i);
      check("idle_rvalid", {31'b0, rvalid_o}, 32'd0);
      check("idle_rdata", rdata_o, 32'd0);

      // single frame 0xA5 at CLKDIV=4
      wr("clkdiv4", 32'h08, 32'd4, 4'hF, 1'b0);
      wr("push_a5", 32'h00, 32'hA5, 4'hF, 1'b0);
      wait_tx_low(20);
      frame_check("a5", 8'hA5, 4);
      rd_chk("status_after_a5", 32'h04, 32'h4, 1'b0);

      // fill FIFO with tx disabled, overflow on 9th push
      wr("ctrl_off", 32'h0C, 32'h0, 4'hF, 1'b0);
      for (int i = 0; i < 8; i++) wr("push_fill", 32'h00, 32'(i), 4'hF, 1'b0);
      wr("push_ovf", 32'h00, 32'h99, 4'hF, 1'b1);
      rd_chk("status_full", 32'h04, 32'h0802, 1'b0);

      // back-to-back frames at CLKDIV=2
      apply_reset();
      wr("clkdiv2", 32'h08, 32'd2, 4'hF, 1'b0);
      wr("ctrl_off2", 32'h0C, 32'h0, 4'hF, 1'b0);
      wr("push_01", 32'h00, 32'h01, 4'hF, 1'b0);
      wr("push_02", 32'h00, 32'h02, 4'hF, 1'b0);
      wr("ctrl_on", 32'h0C, 32'h1, 4'hF, 1'b0);
      wait_tx_low(20);
      frame_check("b2b_01", 8'h01, 2);
      @(negedge clk_i);
      frame_check("b2b_02", 8'h02, 2);
      rd_chk("status_after_b2b", 32'h04, 32'h4, 1'b0);

      // interrupt timing at CLKDIV=3
      wr("clkdiv3", 32'h08, 32'd3, 4'hF, 1'b0);
      wr("ctrl_irq", 32'h0C, 32'h3, 4'hF, 1'b0);
      @(negedge clk_i);
      check("intr_idle", {31'b0, intr_o}, 32'd1);
      wr("push_3c", 32'h00, 32'h3C, 4'hF, 1'b0);
      wait_tx_low(20);
      check("intr_busy", {31'b0, intr_o}, 32'd0);
      frame_check("irq_3c", 8'h3C, 3);
      @(negedge clk_i);
      check("intr_stop_end", {31'b0, intr_o}, 32'd0);
      @(negedge clk_i);
      check("intr_after", {31'b0, intr_o}, 32'd1);

      // error responses, CLKDIV zero, byte lanes
      rd_chk("bad_off", 32'h10, 32'h0, 1'b1);
      wr("wr_status", 32'h04, 32'hFFFF_FFFF, 4'hF, 1'b1);
      rd_chk("status_unchg", 32'h04, 32'h4, 1'b0);
      wr("clkdiv0", 32'h08, 32'h0, 4'hF, 1'b0);
      rd_chk("clkdiv_is1", 32'h08, 32'd1, 1'b0);
      wr("clkdiv_be1", 32'h08, 32'h0000_ABCD, 4'b0010, 1'b0);
      rd_chk("clkdiv_lane", 32'h08, 32'h0000_AB01, 1'b0);
      wr("ctrl_be0", 32'h0C, 32'h0, 4'b1110, 1'b0);
      rd_chk("ctrl_lane", 32'h0C, 32'h3, 1'b0);
      wr("push_be0", 32'h00, 32'h77, 4'b1110, 1'b0);
      rd_chk("status_no_push", 32'h04, 32'h4, 1'b0);

      // reset during DATA bit 3
      wr("clkdiv4b", 32'h08, 32'd4, 4'hF, 1'b0);
      wr("ctrl_on2", 32'h0C, 32'h1, 4'hF, 1'b0);
      wr("push_52", 32'h00, 32'h52, 4'hF, 1'b0);
      wait_tx_low(20);
      repeat (16) @(negedge clk_i);
      check("pre_rst_bit3", {31'b0, tx_o}, 32'd0);
      #1 rst_ni = 1'b0;
      #1;
      check("rst_tx_async", {31'b0, tx_o}, 32'd1);
      check("rst_intr_async", {31'b0, intr_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      seen_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         if (tx_o == 1'b0) seen_low = 1'b1;
      end
      check("no_resume", {31'b0, seen_low}, 32'd0);
      rd_chk("status_post_rst", 32'h04, 32'h4, 1'b0);
      rd_chk("clkdiv_post_rst", 32'h08, 32'd16, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
